// File: rtl/ro_freq_counter_if.sv
// Control/readback bundle between the Tiny Tapeout wrapper and the ring-oscillator frequency meter.
// Handshake: start is a level request sampled only while idle; done pulses for one cycle when a result lands.
interface ro_freq_counter_if;
    logic       start;
    logic [1:0] gate_sel;
    logic [1:0] byte_sel;
    logic [7:0] count_byte;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    modport master (
        output start, gate_sel, byte_sel,
        input  count_byte, busy, done, state_dbg
    );

    modport slave (
        input  start, gate_sel, byte_sel,
        output count_byte, busy, done, state_dbg
    );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of osc_in over a
// 2^(GATE_LOG2_MIN + 2*gate_sel) cycle gate window and exposes the result a byte at a time.
module ro_freq_counter #(
    parameter int CNT_W         = 24,
    parameter int GATE_LOG2_MIN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              osc_in,
    ro_freq_counter_if.slave  bus
);

    localparam int GCNT_W = GATE_LOG2_MIN + 6;
    localparam logic [GCNT_W-1:0] GATE_ONES = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        sync_q, sync_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [1:0]        gsel_q, gsel_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic              edge_pulse;
    logic [GCNT_W-1:0] gate_init;
    logic [23:0]       result_ext;
    logic [7:0]        status_byte;

    // sync_q[0]/[1] form the two-flop synchronizer, sync_q[2] is the edge-detect delay.
    assign sync_d     = {sync_q[1:0], osc_in};
    assign edge_pulse = sync_q[1] & ~sync_q[2];

    always_comb begin
        gate_init = GATE_ONES;
        case (bus.gate_sel)
            2'd0:    gate_init = GATE_ONES >> 6;
            2'd1:    gate_init = GATE_ONES >> 4;
            2'd2:    gate_init = GATE_ONES >> 2;
            default: gate_init = GATE_ONES;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        gcnt_d   = gcnt_q;
        gsel_d   = gsel_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                cnt_d   = '0;
                sat_d   = 1'b0;
                gsel_d  = bus.gate_sel;
                gcnt_d  = gate_init;
                state_d = ST_GATE;
            end
            ST_GATE: begin
                // An edge landing in the final gate cycle is still counted.
                if (edge_pulse) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (gcnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                result_d = cnt_q;
                ovf_d    = sat_q;
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            gcnt_q   <= '0;
            gsel_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            gcnt_q   <= gcnt_d;
            gsel_q   <= gsel_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.state_dbg = state_q;

    // Bytes above CNT_W fall into the zero extension and read back as 0.
    assign result_ext  = 24'(result_q);
    assign status_byte = {bus.busy, valid_q, ovf_q, 3'b000, gsel_q};

    always_comb begin
        bus.count_byte = 8'h00;
        case (bus.byte_sel)
            2'd0:    bus.count_byte = result_ext[7:0];
            2'd1:    bus.count_byte = result_ext[15:8];
            2'd2:    bus.count_byte = result_ext[23:16];
            default: bus.count_byte = status_byte;
        endcase
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: a 24-bit and an 8-bit instance share clk, rst_n and osc_in; results are
// compared against table constants and a sample-sequence model of the gate window.
module tb_ro_freq_counter;

    logic clk = 1'b0;
    logic rst_n;
    logic osc_in;

    always #5 clk = ~clk;

    ro_freq_counter_if a_if ();
    ro_freq_counter_if b_if ();

    ro_freq_counter #(.CNT_W(24), .GATE_LOG2_MIN(8)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .bus    (a_if)
    );

    ro_freq_counter #(.CNT_W(8), .GATE_LOG2_MIN(8)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .bus    (b_if)
    );

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   a_done_cnt = 0;
    bit   osc_hist[$];
    int   osc_mode   = 0;   // 0 hold, 1 square wave, 2 random bits
    int   osc_per    = 4;
    int   osc_ph     = 0;
    logic osc_level  = 1'b0;

    // osc_hist[k] is the osc_in value seen by posedge number k.
    always @(posedge clk) begin
        osc_hist.push_back(osc_in);
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (osc_mode == 1 && osc_per >= 2) begin
            osc_in = (osc_ph < osc_per / 2);
            osc_ph = (osc_ph + 1) % osc_per;
        end else if (osc_mode == 2) begin
            osc_in = 1'($urandom_range(0, 1));
        end else begin
            osc_in = osc_level;
        end
    end

    always @(negedge clk) begin
        if (a_if.done === 1'b1) a_done_cnt = a_done_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Rising edges in the W samples starting at the start-sampling edge, saturating at 2^cw-1.
    function automatic int model_count(input int t0, input int w, input int cw, output bit ovf);
        int n;
        int max_v;
        n     = 0;
        ovf   = 1'b0;
        max_v = (1 << cw) - 1;
        for (int j = t0; j < t0 + w; j++) begin
            if (osc_hist[j] && !osc_hist[j-1]) begin
                if (n == max_v) ovf = 1'b1;
                else n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic logic get_done(input bit which);
        return which ? b_if.done : a_if.done;
    endfunction

    function automatic logic get_busy(input bit which);
        return which ? b_if.busy : a_if.busy;
    endfunction

    task automatic drive_start(input bit which, input logic s, input logic [1:0] g);
        if (which) begin
            b_if.start = s;
            b_if.gate_sel = g;
        end else begin
            a_if.start = s;
            a_if.gate_sel = g;
        end
    endtask

    task automatic read_byte(input bit which, input logic [1:0] sel, output logic [7:0] v);
        if (which) b_if.byte_sel = sel;
        else a_if.byte_sel = sel;
        #1;
        v = which ? b_if.count_byte : a_if.count_byte;
    endtask

    task automatic set_osc(input int per, input logic lvl);
        osc_per   = per;
        osc_level = lvl;
        osc_ph    = 0;
        osc_mode  = (per == 0) ? 0 : 1;
    endtask

    // One full measurement: checks busy, done latency and width, then result and status vs the model.
    task automatic measure(input bit which, input logic [1:0] gsel, output int count, output logic [7:0] stat);
        int w, t0, done_cyc, cw, mcnt;
        bit movf;
        logic [7:0] b0, b1, b2;
        w  = 1 << (8 + 2 * int'(gsel));
        cw = which ? 8 : 24;
        @(negedge clk);
        drive_start(which, 1'b1, gsel);
        t0 = cyc;
        @(negedge clk);
        drive_start(which, 1'b0, gsel);
        check("busy_after_start", int'(get_busy(which)), 1);
        done_cyc = -1;
        while (done_cyc < 0 && cyc < t0 + w + 12) begin
            if (get_done(which)) done_cyc = cyc;
            else @(negedge clk);
        end
        check("done_latency", done_cyc - t0, w + 2);
        @(negedge clk);
        check("done_one_cycle", int'(get_done(which)), 0);
        read_byte(which, 2'd0, b0);
        read_byte(which, 2'd1, b1);
        read_byte(which, 2'd2, b2);
        read_byte(which, 2'd3, stat);
        count = int'({b2, b1, b0});
        mcnt  = model_count(t0, w, cw, movf);
        check("result_vs_model", count, mcnt);
        check("status_vs_model", int'(stat), int'({1'b0, 1'b1, movf, 3'b000, gsel}));
    endtask

    typedef struct {
        bit         which;
        int         per;
        logic       lvl;
        logic [1:0] gsel;
        int         exp_cnt;
        logic [7:0] exp_stat;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int cnt, t0, nd, mc, base;
        logic [7:0] stat, b0, v;
        bit movf;

        vecs[0] = '{1'b0, 4,  1'b0, 2'd0, 64,  8'h40};
        vecs[1] = '{1'b0, 8,  1'b0, 2'd1, 128, 8'h41};
        vecs[2] = '{1'b0, 0,  1'b1, 2'd3, 0,   8'h43};
        vecs[3] = '{1'b0, 16, 1'b0, 2'd1, 64,  8'h41};
        vecs[4] = '{1'b1, 4,  1'b0, 2'd2, 255, 8'h62};
        vecs[5] = '{1'b1, 8,  1'b0, 2'd0, 32,  8'h40};

        rst_n  = 1'b0;
        osc_in = 1'b0;
        a_if.start = 1'b0; a_if.gate_sel = 2'd0; a_if.byte_sel = 2'd0;
        b_if.start = 1'b0; b_if.gate_sel = 2'd0; b_if.byte_sel = 2'd0;
        set_osc(4, 1'b0);

        // Reset values on both instances.
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check("reset_busy", int'(get_busy(w[0])), 0);
            check("reset_done", int'(get_done(w[0])), 0);
            for (int s = 0; s < 4; s++) begin
                read_byte(w[0], 2'(s), v);
                check($sformatf("reset_byte%0d_dut%0d", s, w), int'(v), 0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            set_osc(vecs[i].per, vecs[i].lvl);
            repeat (20) @(negedge clk);
            measure(vecs[i].which, vecs[i].gsel, cnt, stat);
            check($sformatf("vec%0d_count", i), cnt, vecs[i].exp_cnt);
            check($sformatf("vec%0d_status", i), int'(stat), int'(vecs[i].exp_stat));
        end

        // Start and gate_sel changes during GATE must not disturb the measurement.
        set_osc(4, 1'b0);
        repeat (20) @(negedge clk);
        base = a_done_cnt;
        a_if.gate_sel = 2'd0;
        a_if.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            a_if.start = k[0];
            a_if.gate_sel = 2'd3;
            @(negedge clk);
        end
        a_if.start = 1'b0;
        while (cyc < t0 + 280) @(negedge clk);
        check("ignored_start_done_count", a_done_cnt - base, 1);
        read_byte(1'b0, 2'd0, b0);
        check("ignored_start_result", int'(b0), 64);
        read_byte(1'b0, 2'd3, stat);
        check("ignored_start_status", int'(stat), 8'h40);
        a_if.gate_sel = 2'd0;

        // Continuous mode: start held high.
        repeat (5) @(negedge clk);
        a_if.start = 1'b1;
        t0 = cyc;
        nd = 0;
        for (int k = 0; k < 3 * 259 + 20 && nd < 3; k++) begin
            @(negedge clk);
            if (a_if.done) begin
                check($sformatf("cont_done_time%0d", nd), cyc - t0, 258 + 259 * nd);
                @(negedge clk);
                read_byte(1'b0, 2'd0, b0);
                check($sformatf("cont_result%0d", nd), int'(b0), 64);
                mc = model_count(t0 + 259 * nd, 256, 24, movf);
                check($sformatf("cont_model%0d", nd), int'(b0), mc);
                nd = nd + 1;
            end
        end
        check("cont_pulse_count", nd, 3);
        a_if.start = 1'b0;
        for (int k = 0; k < 400 && a_if.busy; k++) @(negedge clk);
        check("cont_stop_idle", int'(a_if.busy), 0);

        // Reset in the middle of GATE.
        repeat (5) @(negedge clk);
        a_if.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        a_if.start = 1'b0;
        while (cyc < t0 + 101) @(negedge clk);
        rst_n = 1'b0;
        base = a_done_cnt;
        #1;
        check("midrst_busy", int'(a_if.busy), 0);
        check("midrst_done", int'(a_if.done), 0);
        for (int s = 0; s < 4; s++) begin
            read_byte(1'b0, 2'(s), v);
            check($sformatf("midrst_byte%0d", s), int'(v), 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (280) @(negedge clk);
        check("midrst_no_done", a_done_cnt - base, 0);
        measure(1'b0, 2'd0, cnt, stat);
        check("midrst_remeasure_count", cnt, 64);
        check("midrst_remeasure_status", int'(stat), 8'h40);

        // Randomized oscillator waveforms against the model.
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                set_osc(int'($urandom_range(2, 12)), 1'b0);
            end else begin
                osc_mode = 2;
            end
            repeat (20) @(negedge clk);
            measure(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), cnt, stat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
